// File: rtl/thread_cmd_pkg.sv
// -----------------------------------------------------------------------------
// thread_cmd_pkg
// Shared encodings for the thread command requester:
//   - req_op_e      : core request opcodes (RUN, STOP, NEXT, reserved)
//   - thrd_cmd_e    : command codes presented to the thread manager
//   - thrd_rslt_e   : manager result codes (accepted / busy)
//   - req_state_e   : requester FSM states
//   - TIMER_W       : width of the backoff/timeout down-counter
//   - op_to_cmd()   : maps a RUN/STOP opcode to its manager command code
// -----------------------------------------------------------------------------
package thread_cmd_pkg;

   typedef enum logic [1:0] {
      OP_RUN  = 2'd0,
      OP_STOP = 2'd1,
      OP_NEXT = 2'd2,
      OP_RSVD = 2'd3
   } req_op_e;

   typedef enum logic [3:0] {
      THRD_CMD_NONE = 4'h0,
      THRD_CMD_RUN  = 4'h1,
      THRD_CMD_STOP = 4'h2
   } thrd_cmd_e;

   typedef enum logic [1:0] {
      RSLT_BUSY   = 2'd0,
      RSLT_ACCEPT = 2'd1
   } thrd_rslt_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT      = 3'd2,
      ST_BACKOFF   = 3'd3,
      ST_NEXT_REQ  = 3'd4,
      ST_NEXT_WAIT = 3'd5,
      ST_REPORT    = 3'd6
   } req_state_e;

   // Wide enough for the largest TIMEOUT (255).
   localparam int TIMER_W = 8;

   function automatic logic [3:0] op_to_cmd(input logic [1:0] op);
      logic [3:0] cmd;
      case (op)
         OP_RUN:  cmd = THRD_CMD_RUN;
         OP_STOP: cmd = THRD_CMD_STOP;
         default: cmd = THRD_CMD_NONE;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/req_wait_timer.sv
// -----------------------------------------------------------------------------
// req_wait_timer
// Loadable down-counter shared by the backoff and response-timeout phases.
//   clk, rst   : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over count)
//   load_val   : number of cycles the following phase lasts
//   count      : decrement by one (stops at zero)
//   expire     : high in the last cycle of the loaded phase (counter == 1)
// Loading N and counting every cycle afterwards gives expire in the N-th cycle.
// -----------------------------------------------------------------------------
module req_wait_timer
   import thread_cmd_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         count,
   output logic         expire
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (count && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == ONE);

endmodule

// File: rtl/thread_cmd_requester.sv
// -----------------------------------------------------------------------------
// thread_cmd_requester
// Accepts RUN / STOP / NEXT requests from a core, drives one-cycle commands to
// a thread manager, waits (bounded) for the manager's answer, optionally
// retries busy results after a backoff, and reports completion with a
// one-cycle done pulse.
//
// Configuration macro: THRD_REQ_RETRY_EN
//   defined   : busy results are re-issued up to MAX_RETRY times after BACKOFF
//               idle cycles each.
//   undefined : a busy result completes immediately with done_ok=0; the
//               backoff state is never entered and done_retries stays 0.
//
// Ports
//   clk, rst                         clock, asynchronous active-low reset
//   req_valid/req_ready              core request handshake (ready only in IDLE)
//   req_op/req_data/req_addr         opcode (0 RUN,1 STOP,2 NEXT,3 reserved),
//                                    thread data word and entry address
//   cmd_active/thrd_cmd/cmd_data/    command to manager, valid for one cycle,
//   cmd_addr                         all zero otherwise
//   rsp_valid/thrd_rslt              manager response (1 accepted, 0 busy)
//   next_thread                      one-cycle request for next scheduled thread
//   next_valid/next_data/next_proc   manager's next-thread reply
//   done/done_ok/done_data/          completion pulse and report fields; the
//   done_addr/done_retries           fields hold until the next report
//
// Timing: request accept cycle, ISSUE, first WAIT cycle, REPORT -> done is
// high in the fourth cycle counting the accept cycle. A WAIT phase lasts at
// most TIMEOUT cycles; a busy result with retries left spends exactly BACKOFF
// cycles in BACKOFF before the next ISSUE. Reserved op 3 completes in the
// cycle after acceptance with done_ok=0 and zero report fields.
// -----------------------------------------------------------------------------
module thread_cmd_requester
   import thread_cmd_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MAX_RETRY = 4,
   parameter int BACKOFF   = 3,
   parameter int TIMEOUT   = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [DATA_W-1:0] req_data,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              cmd_active,
   output logic [3:0]        thrd_cmd,
   output logic [DATA_W-1:0] cmd_data,
   output logic [ADDR_W-1:0] cmd_addr,
   input  logic              rsp_valid,
   input  logic [1:0]        thrd_rslt,
   output logic              next_thread,
   input  logic              next_valid,
   input  logic [DATA_W-1:0] next_data,
   input  logic [ADDR_W-1:0] next_proc,
   output logic              done,
   output logic              done_ok,
   output logic [DATA_W-1:0] done_data,
   output logic [ADDR_W-1:0] done_addr,
   output logic [3:0]        done_retries
);

`ifdef THRD_REQ_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   localparam logic [3:0]         MAX_RETRY_L = 4'(MAX_RETRY);
   localparam logic [TIMER_W-1:0] TIMEOUT_L   = TIMER_W'(TIMEOUT);
   localparam logic [TIMER_W-1:0] BACKOFF_L   = TIMER_W'(BACKOFF);

   req_state_e        state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        retry_q, retry_d;

   logic              cmd_active_q, cmd_active_d;
   logic [3:0]        thrd_cmd_q, thrd_cmd_d;
   logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic              next_thread_q, next_thread_d;
   logic              done_q, done_d;
   logic              done_ok_q, done_ok_d;
   logic [DATA_W-1:0] done_data_q, done_data_d;
   logic [ADDR_W-1:0] done_addr_q, done_addr_d;
   logic [3:0]        done_retries_q, done_retries_d;

   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_val;
   logic               tmr_count;
   logic               tmr_expire;

   // Set when a RUN/STOP command finishes; its report echoes the request.
   logic              cmd_finish;
   logic              cmd_finish_ok;

   req_wait_timer #(
      .W(TIMER_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .expire   (tmr_expire)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch can infer a latch.
      state_d        = state_q;
      op_d           = op_q;
      data_d         = data_q;
      addr_d         = addr_q;
      retry_d        = retry_q;
      done_ok_d      = done_ok_q;
      done_data_d    = done_data_q;
      done_addr_d    = done_addr_q;
      done_retries_d = done_retries_q;
      tmr_load       = 1'b0;
      tmr_val        = '0;
      tmr_count      = 1'b0;
      cmd_finish     = 1'b0;
      cmd_finish_ok  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               data_d  = req_data;
               addr_d  = req_addr;
               retry_d = '0;
               case (req_op)
                  OP_RUN, OP_STOP: state_d = ST_ISSUE;
                  OP_NEXT:         state_d = ST_NEXT_REQ;
                  default: begin
                     // Reserved op: report failure without touching the manager.
                     state_d        = ST_REPORT;
                     done_ok_d      = 1'b0;
                     done_data_d    = '0;
                     done_addr_d    = '0;
                     done_retries_d = '0;
                  end
               endcase
            end
         end

         ST_ISSUE: begin
            tmr_load = 1'b1;
            tmr_val  = TIMEOUT_L;
            state_d  = ST_WAIT;
         end

         ST_WAIT: begin
            tmr_count = 1'b1;
            if (rsp_valid) begin
               if (thrd_rslt == RSLT_ACCEPT) begin
                  cmd_finish    = 1'b1;
                  cmd_finish_ok = 1'b1;
               end else if (RETRY_EN && (retry_q < MAX_RETRY_L)) begin
                  tmr_load = 1'b1;
                  tmr_val  = BACKOFF_L;
                  state_d  = ST_BACKOFF;
               end else begin
                  cmd_finish = 1'b1;
               end
            end else if (tmr_expire) begin
               // Timeout ends the command without spending a retry.
               cmd_finish = 1'b1;
            end
         end

         ST_BACKOFF: begin
            tmr_count = 1'b1;
            if (tmr_expire) begin
               retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
               state_d = ST_ISSUE;
            end
         end

         ST_NEXT_REQ: begin
            tmr_load = 1'b1;
            tmr_val  = TIMEOUT_L;
            state_d  = ST_NEXT_WAIT;
         end

         ST_NEXT_WAIT: begin
            tmr_count = 1'b1;
            if (next_valid) begin
               state_d        = ST_REPORT;
               done_ok_d      = 1'b1;
               done_data_d    = next_data;
               done_addr_d    = next_proc;
               done_retries_d = '0;
            end else if (tmr_expire) begin
               state_d        = ST_REPORT;
               done_ok_d      = 1'b0;
               done_data_d    = '0;
               done_addr_d    = '0;
               done_retries_d = '0;
            end
         end

         ST_REPORT: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (cmd_finish) begin
         state_d        = ST_REPORT;
         done_ok_d      = cmd_finish_ok;
         done_data_d    = data_q;
         done_addr_d    = addr_q;
         done_retries_d = retry_q;
      end

      // Outputs are registered: they reflect the state being entered.
      cmd_active_d  = (state_d == ST_ISSUE);
      thrd_cmd_d    = cmd_active_d ? op_to_cmd(op_d) : 4'd0;
      cmd_data_d    = cmd_active_d ? data_d : '0;
      cmd_addr_d    = cmd_active_d ? addr_d : '0;
      next_thread_d = (state_d == ST_NEXT_REQ);
      done_d        = (state_d == ST_REPORT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         op_q           <= '0;
         data_q         <= '0;
         addr_q         <= '0;
         retry_q        <= '0;
         cmd_active_q   <= 1'b0;
         thrd_cmd_q     <= '0;
         cmd_data_q     <= '0;
         cmd_addr_q     <= '0;
         next_thread_q  <= 1'b0;
         done_q         <= 1'b0;
         done_ok_q      <= 1'b0;
         done_data_q    <= '0;
         done_addr_q    <= '0;
         done_retries_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q        <= state_d;
         op_q           <= op_d;
         data_q         <= data_d;
         addr_q         <= addr_d;
         retry_q        <= retry_d;
         cmd_active_q   <= cmd_active_d;
         thrd_cmd_q     <= thrd_cmd_d;
         cmd_data_q     <= cmd_data_d;
         cmd_addr_q     <= cmd_addr_d;
         next_thread_q  <= next_thread_d;
         done_q         <= done_d;
         done_ok_q      <= done_ok_d;
         done_data_q    <= done_data_d;
         done_addr_q    <= done_addr_d;
         done_retries_q <= done_retries_d;
      end
   end

   // Gated by reset so ready reads 0 while reset is held and 1 once released.
   assign req_ready    = rst && (state_q == ST_IDLE);
   assign cmd_active   = cmd_active_q;
   assign thrd_cmd     = thrd_cmd_q;
   assign cmd_data     = cmd_data_q;
   assign cmd_addr     = cmd_addr_q;
   assign next_thread  = next_thread_q;
   assign done         = done_q;
   assign done_ok      = done_ok_q;
   assign done_data    = done_data_q;
   assign done_addr    = done_addr_q;
   assign done_retries = done_retries_q;

endmodule

// File: tb/tb_thread_cmd_requester.sv
// -----------------------------------------------------------------------------
// tb_thread_cmd_requester
// Randomized and directed transactions against a transaction-level model.
// Cycle numbering: cycle 0 is the cycle in which the request is accepted;
// every later cycle is sampled and driven on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_thread_cmd_requester;
   import thread_cmd_pkg::*;

   localparam int DW        = 32;
   localparam int AW        = 32;
   localparam int MAX_RETRY = 4;
   localparam int BACKOFF   = 3;
   localparam int TIMEOUT   = 15;
   localparam int BUDGET    = 200;
   localparam int HW        = DW + AW + 5;

`ifdef THRD_REQ_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [DW-1:0] req_data;
   logic [AW-1:0] req_addr;
   logic          cmd_active;
   logic [3:0]    thrd_cmd;
   logic [DW-1:0] cmd_data;
   logic [AW-1:0] cmd_addr;
   logic          rsp_valid;
   logic [1:0]    thrd_rslt;
   logic          next_thread;
   logic          next_valid;
   logic [DW-1:0] next_data;
   logic [AW-1:0] next_proc;
   logic          done;
   logic          done_ok;
   logic [DW-1:0] done_data;
   logic [AW-1:0] done_addr;
   logic [3:0]    done_retries;

   thread_cmd_requester #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .MAX_RETRY (MAX_RETRY),
      .BACKOFF   (BACKOFF),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_data     (req_data),
      .req_addr     (req_addr),
      .cmd_active   (cmd_active),
      .thrd_cmd     (thrd_cmd),
      .cmd_data     (cmd_data),
      .cmd_addr     (cmd_addr),
      .rsp_valid    (rsp_valid),
      .thrd_rslt    (thrd_rslt),
      .next_thread  (next_thread),
      .next_valid   (next_valid),
      .next_data    (next_data),
      .next_proc    (next_proc),
      .done         (done),
      .done_ok      (done_ok),
      .done_data    (done_data),
      .done_addr    (done_addr),
      .done_retries (done_retries)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Manager behaviour plan: per issue, response delay into WAIT (-1 = never)
   // and whether the result is accepted; NEXT reply delay and payload.
   int            rsp_dly [16];
   bit            rsp_ok  [16];
   int            nx_dly;
   logic [DW-1:0] nx_data;
   logic [AW-1:0] nx_proc;

   // Model predictions for the current transaction.
   int            exp_n_iss;
   int            exp_iss [16];
   int            exp_done;
   bit            exp_ok;
   int            exp_retr;
   bit            exp_next;
   logic [DW-1:0] exp_dd;
   logic [AW-1:0] exp_da;

   // Report fields expected to be held from the previous completion.
   logic [HW-1:0] held;

   task automatic set_plan(input int dly, input bit ok);
      for (int k = 0; k < 16; k++) begin
         rsp_dly[k] = dly;
         rsp_ok[k]  = ok;
      end
   endtask

   // Transaction-level model: walks the issue/response sequence and
   // accumulates cycle numbers arithmetically.
   task automatic model(input logic [1:0] op, input logic [DW-1:0] d, input logic [AW-1:0] a);
      int c;
      int k;
      exp_n_iss = 0;
      exp_next  = 1'b0;
      exp_retr  = 0;
      if (op == OP_NEXT) begin
         exp_next = 1'b1;
         // next_thread in cycle 1, reply window is cycles 2 .. 1+TIMEOUT
         if (nx_dly >= 0 && nx_dly < TIMEOUT) begin
            exp_done = 3 + nx_dly;
            exp_ok   = 1'b1;
            exp_dd   = nx_data;
            exp_da   = nx_proc;
         end else begin
            exp_done = 2 + TIMEOUT;
            exp_ok   = 1'b0;
            exp_dd   = '0;
            exp_da   = '0;
         end
      end else if (op == OP_RSVD) begin
         exp_done = 1;
         exp_ok   = 1'b0;
         exp_dd   = '0;
         exp_da   = '0;
      end else begin
         exp_dd = d;
         exp_da = a;
         c = 1;
         k = 0;
         forever begin
            exp_iss[k] = c;
            exp_n_iss  = k + 1;
            exp_retr   = k;
            if (rsp_dly[k] < 0 || rsp_dly[k] >= TIMEOUT) begin
               // TIMEOUT silent WAIT cycles follow the issue cycle
               exp_done = c + TIMEOUT + 1;
               exp_ok   = 1'b0;
               break;
            end
            exp_done = c + rsp_dly[k] + 2;
            exp_ok   = rsp_ok[k];
            if (rsp_ok[k] || !RETRY_EN || k >= MAX_RETRY) break;
            c = c + rsp_dly[k] + 2 + BACKOFF;
            k++;
         end
      end
   endtask

   task automatic run_txn(input string name, input logic [1:0] op,
                          input logic [DW-1:0] d, input logic [AW-1:0] a);
      int            n_iss;
      int            n_nxt;
      int            n_done;
      int            done_at;
      int            seen_iss [16];
      logic [HW-1:0] rep;
      logic [3:0]    exp_cmd;

      model(op, d, a);
      exp_cmd = (op == OP_STOP) ? 4'(THRD_CMD_STOP) : 4'(THRD_CMD_RUN);
      rep     = '0;

      @(negedge clk);
      check({name, ":held"}, {done_ok, done_data, done_addr, done_retries}, held);
      check({name, ":ready_idle"}, req_ready, 1);
      req_valid = 1'b1;
      req_op    = op;
      req_data  = d;
      req_addr  = a;
      n_iss   = 0;
      n_nxt   = 0;
      n_done  = 0;
      done_at = -1;

      for (int cyc = 1; cyc <= BUDGET; cyc++) begin
         @(negedge clk);
         req_valid  = 1'b0;
         req_op     = 2'($urandom);
         req_data   = $urandom;
         req_addr   = $urandom;
         rsp_valid  = 1'b0;
         thrd_rslt  = 2'($urandom_range(0, 1));
         next_valid = 1'b0;
         next_data  = $urandom;
         next_proc  = $urandom;

         if (cyc == 1) check({name, ":ready_busy"}, req_ready, 0);
         if (cmd_active) begin
            if (n_iss < 16) seen_iss[n_iss] = cyc;
            check({name, ":cmd"}, {thrd_cmd, cmd_data, cmd_addr}, {exp_cmd, d, a});
            n_iss++;
         end
         if (next_thread) n_nxt++;
         if (done) begin
            n_done++;
            done_at = cyc;
            rep     = {done_ok, done_data, done_addr, done_retries};
            check({name, ":cmd_quiet"}, {cmd_active, thrd_cmd, cmd_data, cmd_addr}, 0);
         end

         if (op == OP_NEXT) begin
            // rsp_valid is never looked at in a NEXT flow
            rsp_valid = 1'($urandom_range(0, 1));
            if (nx_dly >= 0 && cyc == 2 + nx_dly) begin
               next_valid = 1'b1;
               next_data  = nx_data;
               next_proc  = nx_proc;
            end else if (next_thread) begin
               next_valid = 1'b1;  // stray reply while the request is still going out
            end
         end else begin
            // next_valid is never looked at outside a NEXT flow
            next_valid = 1'($urandom_range(0, 1));
            if (n_iss > 0 && n_iss <= 16 && rsp_dly[n_iss-1] >= 0 &&
                cyc == seen_iss[n_iss-1] + 1 + rsp_dly[n_iss-1]) begin
               rsp_valid = 1'b1;
               thrd_rslt = rsp_ok[n_iss-1] ? 2'(RSLT_ACCEPT) : 2'(RSLT_BUSY);
            end else if (cmd_active || done) begin
               rsp_valid = 1'($urandom_range(0, 1));
               thrd_rslt = 2'(RSLT_ACCEPT);
            end
         end

         if (done_at >= 0 && cyc >= done_at + 2) break;
      end

      rsp_valid  = 1'b0;
      next_valid = 1'b0;

      check({name, ":done_count"}, n_done, 1);
      check({name, ":done_cycle"}, done_at, exp_done);
      check({name, ":issues"}, n_iss, exp_n_iss);
      for (int k = 0; k < exp_n_iss && k < n_iss && k < 16; k++)
         check({name, ":issue_cycle"}, seen_iss[k], exp_iss[k]);
      check({name, ":next_pulses"}, n_nxt, exp_next);
      held = {exp_ok, exp_dd, exp_da, 4'(exp_retr)};
      check({name, ":report"}, rep, held);
   endtask

   task automatic reset_mid_wait();
      int stray;
      set_plan(-1, 1'b0);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_RUN;
      req_data  = 32'h5A5A_0001;
      req_addr  = 32'h0000_0ABC;
      @(negedge clk);             // cycle 1: ISSUE
      req_valid = 1'b0;
      @(negedge clk);             // cycle 2: WAIT
      #2 rst = 1'b0;
      #1;
      check("rst:outs_zero",
            {req_ready, cmd_active, thrd_cmd, cmd_data, cmd_addr, next_thread,
             done, done_ok, done_data, done_addr, done_retries}, 0);
      stray = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) stray++;
      end
      rst = 1'b1;
      #1 check("rst:ready_after", req_ready, 1);
      repeat (TIMEOUT + 5) begin
         @(negedge clk);
         if (done || cmd_active) stray++;
      end
      check("rst:no_done", stray, 0);
      held = '0;
   endtask

   initial begin
      logic [1:0]    op;
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      int            r;

      rst        = 1'b0;
      req_valid  = 1'b0;
      req_op     = '0;
      req_data   = '0;
      req_addr   = '0;
      rsp_valid  = 1'b0;
      thrd_rslt  = '0;
      next_valid = 1'b0;
      next_data  = '0;
      next_proc  = '0;
      nx_dly     = -1;
      nx_data    = '0;
      nx_proc    = '0;
      held       = '0;
      set_plan(0, 1'b1);

      repeat (3) @(negedge clk);
      check("reset:outs_zero",
            {req_ready, cmd_active, thrd_cmd, cmd_data, cmd_addr, next_thread,
             done, done_ok, done_data, done_addr, done_retries}, 0);
      rst = 1'b1;
      #1 check("reset:ready_after", req_ready, 1);

      // Accepted in the first WAIT cycle.
      set_plan(0, 1'b1);
      run_txn("run_ok", OP_RUN, 32'h11, 32'h100);

      // Busy twice, then accepted.
      set_plan(0, 1'b1);
      rsp_dly[0] = 0; rsp_ok[0] = 1'b0;
      rsp_dly[1] = 0; rsp_ok[1] = 1'b0;
      run_txn("stop_busy2", OP_STOP, 32'hCAFE_0002, 32'h0000_0204);

      // Always busy.
      set_plan(0, 1'b0);
      run_txn("run_busy", OP_RUN, 32'h0BAD_0003, 32'h0000_0300);

      // NEXT reply after 2 cycles.
      nx_dly = 2; nx_data = 32'hAB; nx_proc = 32'h200;
      run_txn("next_ok", OP_NEXT, 32'h0, 32'h0);

      // No response at all.
      set_plan(-1, 1'b0);
      run_txn("run_timeout", OP_RUN, 32'h0000_7777, 32'h0000_0404);

      // Response in the last WAIT cycle, and one cycle too late.
      set_plan(TIMEOUT - 1, 1'b1);
      run_txn("run_last", OP_RUN, 32'h1234_5678, 32'h0000_0500);
      set_plan(TIMEOUT, 1'b1);
      run_txn("run_late", OP_STOP, 32'h8765_4321, 32'h0000_0600);

      // NEXT with no reply.
      nx_dly = TIMEOUT; nx_data = 32'hDEAD; nx_proc = 32'hBEEF;
      run_txn("next_timeout", OP_NEXT, 32'h0, 32'h0);

      // Reserved opcode.
      run_txn("op_rsvd", OP_RSVD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      reset_mid_wait();
      set_plan(1, 1'b1);
      run_txn("after_rst", OP_RUN, 32'h0000_00C1, 32'h0000_00C2);

      for (int t = 0; t < 40; t++) begin
         op = 2'($urandom_range(0, 3));
         d  = $urandom;
         a  = $urandom;
         for (int k = 0; k < 16; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       rsp_dly[k] = $urandom_range(0, 4);
            else if (r == 6) rsp_dly[k] = TIMEOUT - 1;
            else if (r == 7) rsp_dly[k] = TIMEOUT;
            else if (r == 8) rsp_dly[k] = -1;
            else             rsp_dly[k] = 0;
            rsp_ok[k] = ($urandom_range(0, 2) == 0);
         end
         r = $urandom_range(0, 9);
         if (r < 7)       nx_dly = $urandom_range(0, 5);
         else if (r == 7) nx_dly = TIMEOUT - 1;
         else             nx_dly = TIMEOUT;
         nx_data = $urandom;
         nx_proc = $urandom;
         run_txn("rand", op, d, a);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/thread_cmd_requester.md
THREAD_CMD_REQUESTER -- requirements
Module: thread_cmd_requester

Interface
REQ-001 Parameter DATA_W, default 32, width of thread data word.
REQ-002 Parameter ADDR_W, default 32, width of thread entry address.
REQ-003 Parameter MAX_RETRY, default 4, re-issues allowed after a busy result (1..15).
REQ-004 Parameter BACKOFF, default 3, idle cycles between busy result and re-issue (1..15).
REQ-005 Parameter TIMEOUT, default 15, cycles to wait for a manager response (1..255).
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 req_valid / req_ready  in / out  1 / 1  core request handshake.
REQ-009 req_op  in  2  0=RUN, 1=STOP, 2=NEXT, 3=reserved.
REQ-010 req_data / req_addr  in  DATA_W / ADDR_W  thread data and entry address for RUN/STOP.
REQ-011 cmd_active  out  1  high while a RUN/STOP command is presented to the manager.
REQ-012 thrd_cmd  out  4  command code, 0 when cmd_active low.
REQ-013 cmd_data / cmd_addr  out  DATA_W / ADDR_W  held copies of req_data/req_addr, 0 when cmd_active low.
REQ-014 rsp_valid / thrd_rslt  in / in  1 / 2  manager response strobe and result (1=accepted, 0=busy).
REQ-015 next_thread  out  1  one-cycle pulse requesting the next scheduled thread.
REQ-016 next_valid / next_data / next_proc  in  1 / DATA_W / ADDR_W  manager's next-thread reply.
REQ-017 done / done_ok / done_data / done_addr / done_retries  out  1/1/DATA_W/ADDR_W/4  completion report.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, BACKOFF, NEXT_REQ, NEXT_WAIT, REPORT.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-020 Accepted RUN/STOP SHALL latch op/data/addr, clear retry count, and go to ISSUE the next cycle.
REQ-021 ISSUE SHALL assert cmd_active with the latched command for exactly one cycle, then go to WAIT.
REQ-022 WAIT: rsp_valid with thrd_rslt=1 -> REPORT with done_ok=1; thrd_rslt=0 -> BACKOFF if retries<MAX_RETRY, else REPORT with done_ok=0.
REQ-023 WAIT with no rsp_valid for TIMEOUT cycles -> REPORT with done_ok=0; the timeout SHALL NOT consume a retry.
REQ-024 BACKOFF SHALL wait exactly BACKOFF cycles, increment retry count (saturating at 15), and return to ISSUE.
REQ-025 Accepted NEXT SHALL go to NEXT_REQ, pulse next_thread for one cycle, then go to NEXT_WAIT.
REQ-026 NEXT_WAIT: next_valid -> capture next_data/next_proc into done_data/done_addr and go to REPORT with done_ok=1; TIMEOUT expiry -> REPORT with done_ok=0 and done_data/done_addr=0.
REQ-027 REPORT SHALL pulse done for one cycle and return to IDLE; done_ok, done_data, done_addr and done_retries hold until the next REPORT.
REQ-028 For RUN/STOP, done_data/done_addr SHALL echo the latched request.
REQ-029 rsp_valid or next_valid outside WAIT/NEXT_WAIT SHALL be ignored.
REQ-030 Op 3 SHALL be accepted and reported as done_ok=0 with zero retries, with no manager activity.
REQ-031 Request-to-done latency with immediate acceptance SHALL be 4 cycles (accept, ISSUE, WAIT, REPORT).

Reset
REQ-032 Assertion of rst SHALL force IDLE immediately, clear all counters, and drive every output to 0, except req_ready, which is 1 after release; an in-flight command is abandoned without a done pulse.

Configuration
REQ-033 With THRD_REQ_RETRY_EN defined, busy results SHALL be retried per REQ-022/024.
REQ-034 Without THRD_REQ_RETRY_EN, a busy result SHALL go directly to REPORT with done_ok=0, BACKOFF SHALL be unreachable, and done_retries SHALL be constant 0.

Structure
REQ-035 Thread command codes (RUN, STOP), the req_op encodings and the result codes SHALL live in the shared package thread_cmd_pkg.
REQ-036 The backoff/timeout down-counter SHALL be the sub-module req_wait_timer (load, count, expire).

Verification
REQ-037 RUN data=0x11 addr=0x100, rsp_valid+rslt=1 in the first WAIT cycle -> done=1 four cycles after accept, done_ok=1, done_retries=0.
REQ-038 STOP with busy 2 times, then accepted (RETRY_EN, BACKOFF=3) -> cmd_active pulses 3 times, spaced by 3 idle cycles, done_ok=1, done_retries=2.
REQ-039 RUN always busy, MAX_RETRY=4 -> 5 issues, done_ok=0, done_retries=4; without the macro -> 1 issue, done_ok=0.
REQ-040 NEXT with next_valid, next_data=0xAB and next_proc=0x200 after 2 cycles -> single next_thread pulse, done_data=0xAB, done_addr=0x200.
REQ-041 RUN with no response, TIMEOUT=15 -> done_ok=0 exactly 15 cycles after ISSUE.
REQ-042 rst low during WAIT -> outputs 0 at once, no done pulse; req_ready=1 after release.
